// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus signals between a master and the memory slave
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic                  pwakeup;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (output psel, penable, pwrite, pwakeup, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, pwakeup, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave word memory with fixed wait states and error response
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input logic            pclk,
  input logic            preset,
  apb_slave_mem_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write;
  logic                  err;
  logic [3:0]            cnt;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  setup_err;
  assign setup_err   = ({1'b0, bus.paddr} >= LIM) || !bus.pwakeup;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;
  // The response is registered one edge ahead, so the ready cycle is decided on the preceding edge.
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      write     <= 1'b0;
      err       <= 1'b0;
      cnt       <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      if (pready_q) begin
        if (write && !err) mem[addr] <= wdata;
        state <= IDLE;
        cnt   <= 4'd0;
      end else if (state == IDLE) begin
        if (bus.psel && !bus.penable) begin
          state <= SETUP;
          addr  <= bus.paddr[IW-1:0];
          wdata <= bus.pwdata;
          write <= bus.pwrite;
          err   <= setup_err;
          cnt   <= WC;
          if (WC == 4'd0) begin
            pready_q  <= 1'b1;
            pslverr_q <= setup_err;
            prdata_q  <= (!bus.pwrite && !setup_err) ? mem[bus.paddr[IW-1:0]] : '0;
          end
        end
      end else if (bus.psel && bus.penable) begin
        state <= ACCESS;
        cnt   <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          pready_q  <= 1'b1;
          pslverr_q <= err;
          prdata_q  <= (!write && !err) ? mem[addr] : '0;
        end
      end else begin
        state <= IDLE;
        cnt   <= 4'd0;
      end
    end
endmodule
